// File: rtl/bp_mmio_initiator_if.sv
// bp_mmio_initiator_if
//   Bus bundle for bp_mmio_initiator: host request/response port plus the
//   CCE-MEM command/response port.
//
//   Handshakes:
//     req      : accepted on a cycle where req_v_i & req_ready_o.
//     mem_cmd  : valid/ready. The initiator raises mem_cmd_v_o independently of
//                mem_cmd_ready_i and holds the command stable until the cycle
//                where both are high.
//     mem_resp : valid->yumi. The device holds mem_resp_v_i; the initiator
//                pulses mem_resp_yumi_o in the cycle it consumes the message.
//     rsp      : valid->yumi. rsp_v_o and its payload stay stable until the
//                host pulses rsp_yumi_i.
//
//   CCE-MEM message layout (LSB first):
//     [3:0]                         msg_type (2 = uc_rd, 3 = uc_wr)
//     [4 +: paddr_width_p]          addr
//     [.. +: 3]                     size (0 = 1B .. 3 = 8B)
//     [.. +: payload width]         payload
//     [.. +: cce block width]       data
//
//   Modports: master = initiator side, slave = host/device side.
interface bp_mmio_initiator_if #(
  parameter int paddr_width_p        = 40,
  parameter int dword_width_p        = 64,
  parameter int cce_mem_msg_width_lp = 4 + 40 + 3 + 16 + 512
);
  logic                            req_v_i;
  logic                            req_ready_o;
  logic                            req_wr_not_rd_i;
  logic [paddr_width_p-1:0]        req_addr_i;
  logic [dword_width_p-1:0]        req_data_i;
  logic [1:0]                      req_size_i;

  logic [cce_mem_msg_width_lp-1:0] mem_cmd_o;
  logic                            mem_cmd_v_o;
  logic                            mem_cmd_ready_i;

  logic [cce_mem_msg_width_lp-1:0] mem_resp_i;
  logic                            mem_resp_v_i;
  logic                            mem_resp_yumi_o;

  logic                            rsp_v_o;
  logic                            rsp_yumi_i;
  logic [dword_width_p-1:0]        rsp_data_o;
  logic                            rsp_wr_not_rd_o;
  logic                            rsp_err_o;

  modport master (
    input  req_v_i, req_wr_not_rd_i, req_addr_i, req_data_i, req_size_i,
    output req_ready_o,
    output mem_cmd_o, mem_cmd_v_o,
    input  mem_cmd_ready_i,
    input  mem_resp_i, mem_resp_v_i,
    output mem_resp_yumi_o,
    output rsp_v_o, rsp_data_o, rsp_wr_not_rd_o, rsp_err_o,
    input  rsp_yumi_i
  );

  modport slave (
    output req_v_i, req_wr_not_rd_i, req_addr_i, req_data_i, req_size_i,
    input  req_ready_o,
    input  mem_cmd_o, mem_cmd_v_o,
    output mem_cmd_ready_i,
    output mem_resp_i, mem_resp_v_i,
    input  mem_resp_yumi_o,
    input  rsp_v_o, rsp_data_o, rsp_wr_not_rd_o, rsp_err_o,
    output rsp_yumi_i
  );
endinterface

// File: rtl/bp_mmio_initiator.sv
// bp_mmio_initiator
//   Uncached single-outstanding initiator for the CCE-MEM interface. A host
//   request becomes one e_cce_mem_uc_rd / e_cce_mem_uc_wr command; the device
//   response is returned to the host with an error flag on address mismatch.
//
//   Optional feature, macro BP_MMIO_INITIATOR_TIMEOUT_EN:
//     e_wait is abandoned after timeout_cycles_p cycles (rsp_err_o = 1, data
//     all-ones) and a 2-bit saturating stale count remembers how many late
//     responses must be drained. Without the macro e_wait waits forever.
//
//   Ports:
//     clk_i    clock
//     reset_i  synchronous active-high reset
//     bus      bp_mmio_initiator_if.master (host request/response, CCE-MEM
//              command/response; handshake rules are in the interface file)
//     state_o  current FSM state (0 ready, 1 send, 2 wait, 3 resp)
//
//   cce_block_width_p must be larger than dword_width_p.
module bp_mmio_initiator #(
  parameter int paddr_width_p     = 40,
  parameter int dword_width_p     = 64,
  parameter int cce_block_width_p = 512,
  parameter int payload_width_p   = 16,
  parameter int timeout_cycles_p  = 1024
) (
  input  logic                clk_i,
  input  logic                reset_i,
  bp_mmio_initiator_if.master bus,
  output logic [1:0]          state_o
);

  localparam int addr_lsb_lp = 4;
  localparam int size_lsb_lp = addr_lsb_lp + paddr_width_p;
  localparam int pay_lsb_lp  = size_lsb_lp + 3;
  localparam int data_lsb_lp = pay_lsb_lp + payload_width_p;
  localparam int msg_w_lp    = data_lsb_lp + cce_block_width_p;

  localparam logic [3:0] uc_rd_lp = 4'd2;
  localparam logic [3:0] uc_wr_lp = 4'd3;

  if (timeout_cycles_p < 2) begin : g_bad_timeout
    $error("timeout_cycles_p must be at least 2");
  end

  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_send  = 2'd1,
    e_wait  = 2'd2,
    e_resp  = 2'd3
  } state_e;

  state_e state_r, state_n;

  logic                     wr_r;
  logic [paddr_width_p-1:0] addr_r;
  logic [dword_width_p-1:0] data_r;
  logic [1:0]               size_r;
  logic [dword_width_p-1:0] rsp_data_r;
  logic                     rsp_err_r;

  logic req_ready;
  logic accept;
  logic capture;
  logic tmo_fire;
  logic drain;
  logic tmo_hit;
  logic [1:0] stale_cnt;

  logic [paddr_width_p-1:0] resp_addr;
  logic [dword_width_p-1:0] resp_data;

  assign resp_addr = bus.mem_resp_i[addr_lsb_lp +: paddr_width_p];
  assign resp_data = bus.mem_resp_i[data_lsb_lp +: dword_width_p];

  // Command is built purely from registers so it cannot change while held.
  // The 2-bit host size maps directly onto e_mem_size_1..e_mem_size_8.
  assign bus.mem_cmd_o = {
    {(cce_block_width_p - dword_width_p){1'b0}}, data_r,
    {payload_width_p{1'b0}},
    {1'b0, size_r},
    addr_r,
    (wr_r ? uc_wr_lp : uc_rd_lp)
  };

  always_comb begin
    state_n      = state_r;
    req_ready    = 1'b0;
    accept       = 1'b0;
    capture      = 1'b0;
    tmo_fire     = 1'b0;
    drain        = 1'b0;
    bus.mem_cmd_v_o     = 1'b0;
    bus.mem_resp_yumi_o = 1'b0;
    bus.rsp_v_o         = 1'b0;

    case (state_r)
      e_ready: begin
        // A saturated stale count blocks new work until a late reply drains.
        req_ready = (stale_cnt != 2'd3);
        accept    = req_ready & bus.req_v_i;
        if (accept) state_n = e_send;
      end
      e_send: begin
        bus.mem_cmd_v_o = 1'b1;
        if (bus.mem_cmd_ready_i) state_n = e_wait;
      end
      e_wait: begin
        bus.mem_resp_yumi_o = bus.mem_resp_v_i;
        if (bus.mem_resp_v_i) begin
          if (stale_cnt == 2'd0) begin
            capture = 1'b1;
            state_n = e_resp;
          end else begin
            drain = 1'b1;
          end
        end else if (tmo_hit) begin
          // A response in the same cycle takes the branch above instead.
          tmo_fire = 1'b1;
          state_n  = e_resp;
        end
      end
      e_resp: begin
        bus.rsp_v_o = 1'b1;
        if (bus.rsp_yumi_i) state_n = e_ready;
      end
      default: state_n = e_ready;
    endcase

    // Late replies to abandoned commands are swallowed in any other state.
    if ((state_r != e_wait) && (stale_cnt != 2'd0) && bus.mem_resp_v_i) begin
      bus.mem_resp_yumi_o = 1'b1;
      drain               = 1'b1;
    end
  end

  assign bus.req_ready_o     = req_ready & ~reset_i;
  assign bus.rsp_data_o      = rsp_data_r;
  assign bus.rsp_err_o       = rsp_err_r;
  assign bus.rsp_wr_not_rd_o = wr_r;
  assign state_o             = state_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_ready;
      wr_r       <= 1'b0;
      addr_r     <= '0;
      data_r     <= '0;
      size_r     <= 2'd0;
      rsp_data_r <= '0;
      rsp_err_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      if (accept) begin
        wr_r   <= bus.req_wr_not_rd_i;
        addr_r <= bus.req_addr_i;
        data_r <= bus.req_data_i;
        size_r <= bus.req_size_i;
      end
      if (capture) begin
        rsp_data_r <= wr_r ? '0 : resp_data;
        rsp_err_r  <= (resp_addr != addr_r);
      end else if (tmo_fire) begin
        rsp_data_r <= '1;
        rsp_err_r  <= 1'b1;
      end
    end
  end

`ifdef BP_MMIO_INITIATOR_TIMEOUT_EN
  localparam int cnt_w_lp = $clog2(timeout_cycles_p + 1);

  logic [cnt_w_lp-1:0] tmo_cnt_r;
  logic [1:0]          stale_r;

  // Counter reads 0 in the first e_wait cycle, so the hit lands on the
  // timeout_cycles_p-th cycle spent waiting.
  assign tmo_hit   = (tmo_cnt_r == cnt_w_lp'(timeout_cycles_p - 1));
  assign stale_cnt = stale_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tmo_cnt_r <= '0;
      stale_r   <= 2'd0;
    end else begin
      if (state_r != e_wait) tmo_cnt_r <= '0;
      else                   tmo_cnt_r <= tmo_cnt_r + 1'b1;

      // Timeout and drain are mutually exclusive: a timeout only fires when
      // no response is present.
      if (tmo_fire) begin
        if (stale_r != 2'd3) stale_r <= stale_r + 2'd1;
      end else if (drain) begin
        stale_r <= stale_r - 2'd1;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0,
                       bus.mem_resp_i[addr_lsb_lp-1:0],
                       bus.mem_resp_i[data_lsb_lp-1:size_lsb_lp],
                       bus.mem_resp_i[msg_w_lp-1:data_lsb_lp+dword_width_p]};
`else
  assign tmo_hit   = 1'b0;
  assign stale_cnt = 2'd0;

  logic unused_ok;
  assign unused_ok = &{1'b0, drain,
                       bus.mem_resp_i[addr_lsb_lp-1:0],
                       bus.mem_resp_i[data_lsb_lp-1:size_lsb_lp],
                       bus.mem_resp_i[msg_w_lp-1:data_lsb_lp+dword_width_p]};
`endif

endmodule

// File: tb/tb_bp_mmio_initiator.sv
// tb_bp_mmio_initiator
//   Directed bench for bp_mmio_initiator. Inputs are driven and outputs are
//   sampled on the falling clock edge; the DUT registers on the rising edge.
module tb_bp_mmio_initiator;

  localparam int paddr_w  = 40;
  localparam int dword_w  = 64;
  localparam int block_w  = 512;
  localparam int pay_w    = 16;
  localparam int addr_lsb = 4;
  localparam int size_lsb = addr_lsb + paddr_w;
  localparam int pay_lsb  = size_lsb + 3;
  localparam int data_lsb = pay_lsb + pay_w;
  localparam int msg_w    = data_lsb + block_w;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] dut_state;

  always #5 clk = ~clk;

  bp_mmio_initiator_if #(
    .paddr_width_p       (paddr_w),
    .dword_width_p       (dword_w),
    .cce_mem_msg_width_lp(msg_w)
  ) bus_if ();

  bp_mmio_initiator #(
    .paddr_width_p    (paddr_w),
    .dword_width_p    (dword_w),
    .cce_block_width_p(block_w),
    .payload_width_p  (pay_w),
    .timeout_cycles_p (8)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus_if),
    .state_o(dut_state)
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [msg_w-1:0] mk_resp(input logic [39:0] addr,
                                               input logic [63:0] data,
                                               input logic wr);
    logic [msg_w-1:0] m;
    m = '0;
    m[3:0] = wr ? 4'd3 : 4'd2;
    m[addr_lsb +: paddr_w] = addr;
    m[size_lsb +: 3] = 3'd3;
    m[data_lsb +: dword_w] = data;
    return m;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic wr, input logic [39:0] addr,
                           input logic [63:0] wdata, input logic [1:0] size);
    bus_if.req_v_i         = 1'b1;
    bus_if.req_wr_not_rd_i = wr;
    bus_if.req_addr_i      = addr;
    bus_if.req_data_i      = wdata;
    bus_if.req_size_i      = size;
  endtask

  // One full transaction starting on a falling edge with the DUT in e_ready.
  task automatic do_txn(input string tag, input logic wr, input logic [39:0] addr,
                        input logic [63:0] wdata, input logic [1:0] size,
                        input logic [39:0] raddr, input logic [63:0] rdata,
                        input int cmd_stall, input int yumi_stall);
    logic [msg_w-1:0] snap;
    logic [63:0] rsnap;
    logic [3:0] exp_type;
    exp_type = wr ? 4'd3 : 4'd2;

    // request cycle
    chk({tag, ".req_ready"}, 64'(bus_if.req_ready_o), 64'd1);
    drive_req(wr, addr, wdata, size);
    bus_if.mem_cmd_ready_i = 1'b0;
    exp_q.push_back(wr ? 64'd0 : rdata);
    @(negedge clk);
    bus_if.req_v_i = 1'b0;

    // e_send
    snap = bus_if.mem_cmd_o;
    chk({tag, ".cmd_v"},     64'(bus_if.mem_cmd_v_o), 64'd1);
    chk({tag, ".cmd_type"},  64'(snap[3:0]), 64'(exp_type));
    chk({tag, ".cmd_addr"},  64'(snap[addr_lsb +: paddr_w]), 64'(addr));
    chk({tag, ".cmd_size"},  64'(snap[size_lsb +: 3]), 64'(size));
    chk({tag, ".cmd_pay"},   64'(snap[pay_lsb +: pay_w]), 64'd0);
    chk({tag, ".cmd_data"},  snap[data_lsb +: dword_w], wdata);
    chk({tag, ".cmd_dhi"},   64'(|snap[msg_w-1:data_lsb+dword_w]), 64'd0);
    chk({tag, ".req_busy"},  64'(bus_if.req_ready_o), 64'd0);
    for (int i = 0; i < cmd_stall; i++) begin
      @(negedge clk);
      chk({tag, ".hold_v"},      64'(bus_if.mem_cmd_v_o), 64'd1);
      chk({tag, ".hold_stable"}, 64'(bus_if.mem_cmd_o === snap), 64'd1);
      chk({tag, ".hold_busy"},   64'(bus_if.req_ready_o), 64'd0);
    end
    bus_if.mem_cmd_ready_i = 1'b1;
    @(negedge clk);
    bus_if.mem_cmd_ready_i = 1'b0;

    // e_wait
    chk({tag, ".wait_rsp_v"}, 64'(bus_if.rsp_v_o), 64'd0);
    chk({tag, ".wait_cmd_v"}, 64'(bus_if.mem_cmd_v_o), 64'd0);
    bus_if.mem_resp_i   = mk_resp(raddr, rdata, wr);
    bus_if.mem_resp_v_i = 1'b1;
    #1;
    chk({tag, ".yumi"}, 64'(bus_if.mem_resp_yumi_o), 64'd1);
    @(negedge clk);
    bus_if.mem_resp_v_i = 1'b0;

    // e_resp
    chk({tag, ".rsp_v"},    64'(bus_if.rsp_v_o), 64'd1);
    chk({tag, ".rsp_data"}, bus_if.rsp_data_o, exp_q.pop_front());
    chk({tag, ".rsp_err"},  64'(bus_if.rsp_err_o), 64'(raddr != addr));
    chk({tag, ".rsp_wr"},   64'(bus_if.rsp_wr_not_rd_o), 64'(wr));
    rsnap = bus_if.rsp_data_o;
    for (int i = 0; i < yumi_stall; i++) begin
      @(negedge clk);
      chk({tag, ".rhold_v"}, 64'(bus_if.rsp_v_o), 64'd1);
      chk({tag, ".rhold_d"}, bus_if.rsp_data_o, rsnap);
    end
    bus_if.rsp_yumi_i = 1'b1;
    chk({tag, ".no_bypass"}, 64'(bus_if.req_ready_o), 64'd0);
    @(negedge clk);
    bus_if.rsp_yumi_i = 1'b0;
    chk({tag, ".done_v"},     64'(bus_if.rsp_v_o), 64'd0);
    chk({tag, ".done_ready"}, 64'(bus_if.req_ready_o), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus_if.req_v_i         = 1'b0;
    bus_if.req_wr_not_rd_i = 1'b0;
    bus_if.req_addr_i      = '0;
    bus_if.req_data_i      = '0;
    bus_if.req_size_i      = 2'd0;
    bus_if.mem_cmd_ready_i = 1'b0;
    bus_if.mem_resp_i      = '0;
    bus_if.mem_resp_v_i    = 1'b0;
    bus_if.rsp_yumi_i      = 1'b0;
    rst = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset.req_ready", 64'(bus_if.req_ready_o), 64'd0);
    chk("reset.cmd_v",     64'(bus_if.mem_cmd_v_o), 64'd0);
    chk("reset.yumi",      64'(bus_if.mem_resp_yumi_o), 64'd0);
    chk("reset.rsp_v",     64'(bus_if.rsp_v_o), 64'd0);
    chk("reset.rsp_err",   64'(bus_if.rsp_err_o), 64'd0);
    chk("reset.rsp_data",  bus_if.rsp_data_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.ready_after", 64'(bus_if.req_ready_o), 64'd1);
    chk("reset.state",       64'(dut_state), 64'd0);

    do_txn("wr",   1'b1, 40'h00_0030_0008, 64'h1,  2'd3, 40'h00_0030_0008, 64'hffff_0000_ffff_0000, 0, 0);
    do_txn("rd",   1'b0, 40'h00_0030_bff8, 64'h0,  2'd3, 40'h00_0030_bff8, 64'h1234_5678_9abc_def0, 0, 0);
    do_txn("bp",   1'b0, 40'h00_0030_4000, 64'h0,  2'd2, 40'h00_0030_4000, 64'h0000_0000_cafe_f00d, 5, 4);
    do_txn("wr_b", 1'b1, 40'h00_0030_0001, 64'ha5, 2'd0, 40'h00_0030_0001, 64'h77, 0, 0);
    do_txn("rd_h", 1'b0, 40'h00_0030_0002, 64'h0,  2'd1, 40'h00_0030_0002, 64'hbeef, 2, 1);
    do_txn("mis",  1'b0, 40'h00_0030_0008, 64'h0,  2'd3, 40'h00_0030_0010, 64'h55aa_55aa_0f0f_f0f0, 0, 0);

    // reset while waiting for a response; error/data from "mis" must clear
    drive_req(1'b0, 40'h00_0030_0040, 64'h0, 2'd3);
    bus_if.mem_cmd_ready_i = 1'b1;
    @(negedge clk);
    bus_if.req_v_i = 1'b0;
    chk("rstmid.cmd_v", 64'(bus_if.mem_cmd_v_o), 64'd1);
    @(negedge clk);
    bus_if.mem_cmd_ready_i = 1'b0;
    chk("rstmid.in_wait", 64'(dut_state), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.req_ready", 64'(bus_if.req_ready_o), 64'd0);
    chk("rstmid.cmd_v0",    64'(bus_if.mem_cmd_v_o), 64'd0);
    chk("rstmid.rsp_v",     64'(bus_if.rsp_v_o), 64'd0);
    chk("rstmid.rsp_err",   64'(bus_if.rsp_err_o), 64'd0);
    chk("rstmid.rsp_data",  bus_if.rsp_data_o, 64'd0);
    chk("rstmid.state",     64'(dut_state), 64'd0);
    bus_if.mem_resp_i   = mk_resp(40'h00_0030_0040, 64'h99, 1'b0);
    bus_if.mem_resp_v_i = 1'b1;
    #1;
    chk("rstmid.yumi", 64'(bus_if.mem_resp_yumi_o), 64'd0);
    bus_if.mem_resp_v_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid.ready_after", 64'(bus_if.req_ready_o), 64'd1);
    chk("rstmid.no_reissue",  64'(bus_if.mem_cmd_v_o), 64'd0);

`ifdef BP_MMIO_INITIATOR_TIMEOUT_EN
    // no response: abandoned after 8 e_wait cycles
    drive_req(1'b0, 40'h00_0030_0020, 64'h0, 2'd3);
    bus_if.mem_cmd_ready_i = 1'b1;
    exp_q.push_back(64'hffff_ffff_ffff_ffff);
    @(negedge clk);
    bus_if.req_v_i = 1'b0;
    chk("to.cmd_v", 64'(bus_if.mem_cmd_v_o), 64'd1);
    @(negedge clk);
    bus_if.mem_cmd_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("to.wait_rsp_v", 64'(bus_if.rsp_v_o), 64'd0);
      @(negedge clk);
    end
    chk("to.rsp_v",    64'(bus_if.rsp_v_o), 64'd1);
    chk("to.rsp_err",  64'(bus_if.rsp_err_o), 64'd1);
    chk("to.rsp_data", bus_if.rsp_data_o, exp_q.pop_front());
    bus_if.rsp_yumi_i = 1'b1;
    @(negedge clk);
    bus_if.rsp_yumi_i = 1'b0;
    chk("to.ready", 64'(bus_if.req_ready_o), 64'd1);
    // late reply arrives in e_ready and is drained
    bus_if.mem_resp_i   = mk_resp(40'h00_0030_0020, 64'hdead, 1'b0);
    bus_if.mem_resp_v_i = 1'b1;
    #1;
    chk("drain.yumi", 64'(bus_if.mem_resp_yumi_o), 64'd1);
    @(negedge clk);
    bus_if.mem_resp_v_i = 1'b0;
    chk("drain.state", 64'(dut_state), 64'd0);
    #1;
    chk("drain.no_yumi", 64'(bus_if.mem_resp_yumi_o), 64'd0);
`else
    // stray response outside e_wait is left alone
    bus_if.mem_resp_i   = mk_resp(40'h00_0030_0020, 64'hdead, 1'b0);
    bus_if.mem_resp_v_i = 1'b1;
    #1;
    chk("stray.yumi", 64'(bus_if.mem_resp_yumi_o), 64'd0);
    @(negedge clk);
    bus_if.mem_resp_v_i = 1'b0;
    chk("stray.state", 64'(dut_state), 64'd0);
`endif

    do_txn("post", 1'b0, 40'h00_0030_bff8, 64'h0, 2'd3, 40'h00_0030_bff8, 64'h0bad_f00d_1357_2468, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bp_mmio_initiator.md
# bp_mmio_initiator

Uncached initiator for the CCE-MEM command/response interface. It turns a single-request host port into `e_cce_mem_uc_rd`/`e_cce_mem_uc_wr` commands aimed at memory-mapped devices such as the CLINT (mipi, mtimecmp, mtime and plic registers), then returns the device response. It sits between a debug/host agent and the `bp_me_cce_to_wormhole_link_master` conversion, on the initiator side of the link the CLINT terminates. It keeps one transaction outstanding, with optional timeout and stale-response draining.

## Interface
- `bp_params_p`, default `e_bp_inv_cfg`: processor configuration; supplies `paddr_width_p`, `dword_width_p` and `cce_block_width_p`.
- `timeout_cycles_p`, default 1024: number of e_wait cycles before the transaction is abandoned; must be ≥ 2.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `req_v_i`  in  1  request valid.
- `req_ready_o`  out  1  request ready; a request is accepted when `req_v_i & req_ready_o`.
- `req_wr_not_rd_i`  in  1  1 = uncached write, 0 = uncached read.
- `req_addr_i`  in  paddr_width_p  device address.
- `req_data_i`  in  dword_width_p  write data.
- `req_size_i`  in  2  log2 of the byte count: 0 = 1B, 1 = 2B, 2 = 4B, 3 = 8B.
- `mem_cmd_o`  out  cce_mem_msg_width_lp  `bp_cce_mem_msg_s` command.
- `mem_cmd_v_o`  out  1  command valid.
- `mem_cmd_ready_i`  in  1  command ready; ready/valid handshake.
- `mem_resp_i`  in  cce_mem_msg_width_lp  `bp_cce_mem_msg_s` response.
- `mem_resp_v_i`  in  1  response valid.
- `mem_resp_yumi_o`  out  1  response consumed; valid→yumi handshake.
- `rsp_v_o`  out  1  host response valid.
- `rsp_yumi_i`  in  1  host response consumed.
- `rsp_data_o`  out  dword_width_p  read data; 0 for writes.
- `rsp_wr_not_rd_o`  out  1  echo of the request type.
- `rsp_err_o`  out  1  timeout or address mismatch.

## Operation
- The FSM has four states: e_ready, e_send, e_wait and e_resp. Reset enters e_ready.
- **e_ready**
  - `req_ready_o` = 1, except while `reset_i` is high or the stale count is 3.
  - On accept, the request is registered: type, address, data (zero-extended to `cce_block_width_p`) and size (mapped to `e_mem_size_1`..`e_mem_size_8`). The payload is '0. The FSM moves to e_send.
- **e_send**
  - `mem_cmd_v_o` = 1, with `mem_cmd_o` driven only from registers.
  - Valid does not depend on ready and is held until `mem_cmd_ready_i`. The FSM then moves to e_wait.
- **e_wait**
  - `mem_resp_yumi_o` = `mem_resp_v_i`.
  - With the stale count at 0, the response is captured: `rsp_data_o` = `mem_resp_i.data[dword_width_p-1:0]` for reads and 0 for writes.
  - `rsp_err_o` is set if `mem_resp_i.addr` ≠ the issued address. The FSM then moves to e_resp.
  - With the stale count nonzero, the response is dropped, the count is decremented, and the FSM stays in e_wait.
- **e_resp**
  - `rsp_v_o` = 1, holding registered data until `rsp_yumi_i`. The FSM then returns to e_ready.
- Outside e_wait (and outside the drain rule below), `mem_resp_yumi_o` = 0 and unexpected responses are left unconsumed.
- There is no bypass: a new request is never accepted in the same cycle `rsp_yumi_i` retires the previous one.

## Timing
- **Reset values:** `req_ready_o` 0 while in reset and 1 the first cycle after. `mem_cmd_v_o`, `mem_resp_yumi_o`, `rsp_v_o`, `rsp_err_o` are 0. `rsp_data_o` is 0. The stale count is 0.
- Reset asserted in mid-transaction returns the FSM to e_ready and discards all state, including the stale count. No command is reissued.
- **Latency:**
  - Request accepted in cycle N gives `mem_cmd_v_o` in N+1.
  - A command handshake in cycle M means responses are accepted from M+1.
  - A response yumi in cycle K gives `rsp_v_o` in K+1.
  - The minimum round trip, with ready and response both immediate, is request at 0, response yumi at 2, `rsp_v_o` at 3.
- The timeout counter clears on entering e_wait and increments each e_wait cycle. Simultaneous response and timeout: the response wins.

## Configuration
- Macro `BP_MMIO_INITIATOR_TIMEOUT_EN`.
- **Defined:**
  - When the counter reaches `timeout_cycles_p` in e_wait, the FSM moves to e_resp with `rsp_err_o` = 1 and `rsp_data_o` = all-ones, and increments the stale count (2-bit, saturating at 3).
  - While the stale count is nonzero, any `mem_resp_v_i` in e_ready, e_send or e_resp is yumi'd, dropped, and the count decremented.
- **Undefined:** there is no counter and no stale logic, e_wait waits indefinitely, and `rsp_err_o` reflects only address mismatch.

## Test plan
- **Write:** write 0x1, size 3, to 0x0030_0008 with immediate ready/response. Expect `mem_cmd_o` type `e_cce_mem_uc_wr`, data 0x1; `rsp_v_o` at cycle 3 with `rsp_data_o` 0, `rsp_err_o` 0.
- **Read:** read 0x0030_bff8 with response data 0x1234_5678_9abc_def0 → `rsp_data_o` 0x1234_5678_9abc_def0, `rsp_wr_not_rd_o` 0.
- **Backpressure:** hold `mem_cmd_ready_i` low for 5 cycles → `mem_cmd_v_o` stays 1 with `mem_cmd_o` stable; `req_ready_o` 0 throughout. Hold `rsp_yumi_i` low for 4 cycles → `rsp_v_o` and `rsp_data_o` stable.
- **Address mismatch:** response address 0x0030_0010 for an issued 0x0030_0008 → `rsp_err_o` 1.
- **Timeout and drain** (macro on, `timeout_cycles_p`=8): no response → `rsp_err_o` 1 and data all-ones after 8 e_wait cycles. A late response arriving in e_ready is yumi'd and dropped. The next read completes with correct data and `rsp_err_o` 0.
- **Reset mid-transaction:** assert reset during e_wait → all outputs return to reset values and `req_ready_o` is 1 the cycle after reset deasserts.
